// File: rtl/alu_bist.sv
// Response-side BIST engine for the 32-bit ALU: LFSR operand pairs are swept through
// ADD/SUB/AND/OR/SLT and every Result+VCNZ is folded into a 32-bit MISR signature.
module alu_bist #(
   parameter int unsigned NUM_VECTORS = 16,
   parameter logic [31:0] SEED_A      = 32'h01234567,
   parameter logic [31:0] SEED_B      = 32'h76543210,
   parameter logic [31:0] LFSR_MASK   = 32'h80200003,
   parameter logic [31:0] MISR_MASK   = 32'h04C11DB7,
   parameter logic [31:0] SIG_INIT    = 32'hFFFFFFFF,
   parameter logic [31:0] GOLDEN_SIG  = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [2:0]  ALUControl,
   output logic [31:0] A,
   output logic [31:0] B,
   input  logic [31:0] Result,
   input  logic        V,
   input  logic        C,
   input  logic        N,
   input  logic        Z,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] signature
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [15:0] VCNT_LAST = 16'(NUM_VECTORS - 1);

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [15:0] vcnt_q, vcnt_d;
   logic [31:0] a_q, a_d, b_q, b_d, sig_q, sig_d;
   logic [2:0]  ctl_q, ctl_d;
   logic        pass_q, pass_d;
   logic [31:0] misr_next;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
   endfunction

   // Op index 4 maps to SLT, which sits at encoding 101 rather than 100.
   function automatic logic [2:0] op_ctl(input logic [2:0] op);
      return (op == 3'd4) ? 3'b101 : op;
   endfunction

   always_comb begin
      misr_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_MASK : 32'h0)
                ^ Result ^ {28'b0, V, C, N, Z};
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      vcnt_d  = vcnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sig_d   = sig_q;
      ctl_d   = ctl_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               op_d    = 3'd0;
               vcnt_d  = 16'd0;
               a_d     = SEED_A;
               b_d     = SEED_B;
               sig_d   = SIG_INIT;
               ctl_d   = op_ctl(3'd0);
               pass_d  = 1'b0;
            end
         end
         S_RUN: begin
            sig_d = misr_next;
            if (op_q == 3'd4) begin
               op_d = 3'd0;
               if (vcnt_q == VCNT_LAST) begin
                  // Operands and control stay on the last vector while DONE holds.
                  state_d = S_DONE;
                  pass_d  = (misr_next == GOLDEN_SIG);
               end else begin
                  vcnt_d = vcnt_q + 16'd1;
                  a_d    = lfsr_step(a_q);
                  b_d    = lfsr_step(b_q);
                  ctl_d  = op_ctl(3'd0);
               end
            end else begin
               op_d  = op_q + 3'd1;
               ctl_d = op_ctl(op_q + 3'd1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 3'd0;
         vcnt_q  <= 16'd0;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         sig_q   <= 32'h0;
         ctl_q   <= 3'b000;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         vcnt_q  <= vcnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sig_q   <= sig_d;
         ctl_q   <= ctl_d;
         pass_q  <= pass_d;
      end
   end

   assign ALUControl = ctl_q;
   assign A          = a_q;
   assign B          = b_q;
   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign pass       = pass_q;
   assign signature  = sig_q;

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Sequential built-in self-test engine for the 32-bit ALU. It is the response side of the ALU operand/control interface.
- It generates operand pairs (A, B) with LFSRs and sweeps each pair through ADD, SUB, AND, OR and SLT.
- It compacts every Result and its VCNZ flags into a 32-bit MISR signature, then reports done/pass.
- It sits beside the ALU in the uni datapath and is used for power-on and bench self-check. The ALU is combinational, so one operation is checked per clock.

Parameters:
- NUM_VECTORS, 16: number of (A, B) operand pairs; range 1..65535.
- SEED_A, 32'h01234567: initial A LFSR value; must be nonzero.
- SEED_B, 32'h76543210: initial B LFSR value; must be nonzero.
- LFSR_MASK, 32'h80200003: Galois feedback mask shared by both LFSRs.
- MISR_MASK, 32'h04C11DB7: MISR feedback mask.
- SIG_INIT, 32'hFFFFFFFF: MISR value loaded at start.
- GOLDEN_SIG, 32'h00000000: expected final signature.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: begin a test run; sampled in IDLE or DONE.
- ALUControl, output, 3: ALU operation select.
- A, output, 32: ALU operand A.
- B, output, 32: ALU operand B.
- Result, input, 32: ALU result.
- V, input, 1: ALU overflow flag.
- C, input, 1: ALU carry flag.
- N, input, 1: ALU negative flag.
- Z, input, 1: ALU zero flag.
- busy, output, 1: high while in RUN.
- done, output, 1: high while in DONE.
- pass, output, 1: valid when done; 1 iff signature == GOLDEN_SIG.
- signature, output, 32: current MISR contents.

Behaviour:
- Reset (rst_n == 0 at a rising edge):
  - State goes to IDLE.
  - ALUControl = 3'b000, A = 0, B = 0, busy = 0, done = 0, pass = 0, signature = 0.
  - op index = 0, vector count = 0.
  - Reset mid-RUN aborts the run immediately; no partial done or pass.
- States: IDLE, RUN, DONE.
- IDLE:
  - With start = 1, load A = SEED_A, B = SEED_B, signature = SIG_INIT, op index = 0, vector count = 0, then go to RUN.
  - With start = 0, stay in IDLE.
- RUN:
  - busy = 1 for exactly 5*NUM_VECTORS cycles.
  - ALUControl is decoded from op index: 0→000 (ADD), 1→001 (SUB), 2→010 (AND), 3→011 (OR), 4→101 (SLT).
  - A, B and ALUControl are registered outputs. Result and VCNZ are sampled combinationally in the same cycle, at the next rising edge.
  - MISR update each RUN edge:
    - sig' = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_MASK : 0) ^ Result ^ {28'b0, V, C, N, Z}.
  - Op index increments each RUN cycle.
  - When op index == 4:
    - Op index wraps to 0.
    - Both LFSRs step: x' = x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1).
    - Vector count increments.
  - Last op of the last vector (op index == 4 and vector count == NUM_VECTORS-1): absorb it, then go to DONE.
  - A and B stay constant across the 5 ops of one vector.
  - start is ignored during RUN.
- DONE:
  - done = 1, busy = 0.
  - pass is registered on the transition into DONE.
  - signature is frozen. A, B and ALUControl hold their last values.
  - start = 1 restarts as from IDLE: done drops on the next edge and signature reloads SIG_INIT.
- start held high continuously: a new run begins on the edge after each DONE entry (one DONE cycle between runs).
- Signature and LFSR arithmetic are modulo 2^32; there is no saturation.
- Latency: start edge to done = 1 + 5*NUM_VECTORS cycles.

Test Plan:
- Reset while rst_n = 0 for 3 cycles, then start = 0 → all outputs 0, state IDLE, busy = 0 indefinitely.
- NUM_VECTORS = 1, pulse start → A = 32'h01234567 and B = 32'h76543210 held for 5 cycles.
  - ALUControl sequence is 000, 001, 010, 011, 101.
  - busy is high for exactly 5 cycles, then done = 1.
  - signature equals the bench model recurrence, fed with ADD result 32'h77777777 first.
- Default params, check the second vector → A = 32'h80B1A2B0, B = 32'h3B2A1908 at cycle 6 of RUN.
  - done asserts exactly 81 cycles after start.
- GOLDEN_SIG set to the model signature → pass = 1.
  - Force a Result bit flip on one cycle (fault injection) → pass = 0, and the signature differs.
- Deassert rst_n at RUN cycle 7 → next edge shows busy = 0, done = 0, signature = 0.
  - A later start yields a signature identical to an uninterrupted run.
- Pulse start during RUN → no effect on the sequence. start in DONE → rerun gives the same signature and pass.
